// File: rtl/rv_mem_bus.sv
// Memory bus bridge between a picorv32-style CPU port and a ROM/RAM pair.
// Decodes the address, runs the slave handshake with a timeout and reports errors.
module rv_mem_bus #(
  parameter int          ROM_ADDR_BITS = 8,
  parameter int          RAM_ADDR_BITS = 8,
  parameter logic [31:0] ROM_BASE      = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE      = 32'h0001_0000,
  parameter int          TIMEOUT       = 15
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic                     rom_addr_valid,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic                     rom_data_valid,
  input  logic [31:0]              rom_data,
  output logic                     ram_addr_valid,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [31:0]              ram_wdata,
  output logic [3:0]               ram_wr_en,
  input  logic                     ram_ack,
  input  logic [31:0]              ram_rdata,
  output logic                     bus_err,
  output logic [7:0]               err_count
);

  typedef enum logic [2:0] {IDLE, ROM, RAM, DONE, ERR} state_t;

  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  state_t                   state_reg, state_next;
  logic [7:0]               tmo_reg, tmo_next;
  logic [7:0]               err_count_reg, err_count_next;
  logic                     mem_ready_reg, mem_ready_next;
  logic [31:0]              mem_rdata_reg, mem_rdata_next;
  logic                     bus_err_reg, bus_err_next;
  logic                     rom_addr_valid_reg, rom_addr_valid_next;
  logic [ROM_ADDR_BITS-1:0] rom_addr_reg, rom_addr_next;
  logic                     ram_addr_valid_reg, ram_addr_valid_next;
  logic [RAM_ADDR_BITS-1:0] ram_addr_reg, ram_addr_next;
  logic [31:0]              ram_wdata_reg, ram_wdata_next;
  logic [3:0]               ram_wr_en_reg, ram_wr_en_next;

  logic [31:0] rom_off, ram_off;
  logic        in_rom, in_ram;
  logic        err_enter;

  // Unsigned subtraction makes addresses below the base wrap high and fall outside.
  assign rom_off = mem_addr - ROM_BASE;
  assign ram_off = mem_addr - RAM_BASE;
  assign in_rom  = (rom_off >> ROM_ADDR_BITS) == 32'd0;
  assign in_ram  = (ram_off >> RAM_ADDR_BITS) == 32'd0;

  always_comb begin
    state_next          = state_reg;
    tmo_next            = tmo_reg;
    err_count_next      = err_count_reg;
    mem_ready_next      = 1'b0;
    mem_rdata_next      = 32'd0;
    bus_err_next        = 1'b0;
    rom_addr_valid_next = 1'b0;
    rom_addr_next       = rom_addr_reg;
    ram_addr_valid_next = 1'b0;
    ram_addr_next       = ram_addr_reg;
    ram_wdata_next      = ram_wdata_reg;
    ram_wr_en_next      = ram_wr_en_reg;
    err_enter           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (mem_valid) begin
          if (in_rom && mem_wstrb == 4'd0) begin
            state_next          = ROM;
            tmo_next            = 8'd0;
            rom_addr_next       = rom_off[ROM_ADDR_BITS-1:0];
            rom_addr_valid_next = 1'b1;
          end else if (in_rom) begin
            err_enter = 1'b1;
          end else if (in_ram) begin
            state_next          = RAM;
            tmo_next            = 8'd0;
            ram_addr_next       = ram_off[RAM_ADDR_BITS-1:0];
            ram_wdata_next      = mem_wdata;
            ram_wr_en_next      = mem_wstrb;
            ram_addr_valid_next = 1'b1;
          end else begin
            err_enter = 1'b1;
          end
        end
      end
      ROM: begin
        if (rom_data_valid) begin
          state_next     = DONE;
          mem_ready_next = 1'b1;
          mem_rdata_next = rom_data;
        end else if (tmo_reg == TMO_LAST) begin
          err_enter = 1'b1;
        end else begin
          tmo_next            = tmo_reg + 8'd1;
          rom_addr_valid_next = 1'b1;
        end
      end
      RAM: begin
        if (ram_ack) begin
          state_next     = DONE;
          mem_ready_next = 1'b1;
          mem_rdata_next = (ram_wr_en_reg == 4'd0) ? ram_rdata : 32'd0;
          ram_wr_en_next = 4'd0;
        end else if (tmo_reg == TMO_LAST) begin
          err_enter = 1'b1;
        end else begin
          tmo_next = tmo_reg + 8'd1;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Error completion shares one path for decode faults and slave timeouts.
    if (err_enter) begin
      state_next     = ERR;
      mem_ready_next = 1'b1;
      mem_rdata_next = ERR_WORD;
      bus_err_next   = 1'b1;
      ram_wr_en_next = 4'd0;
      if (err_count_reg != 8'hFF) err_count_next = err_count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg          <= IDLE;
      tmo_reg            <= 8'd0;
      err_count_reg      <= 8'd0;
      mem_ready_reg      <= 1'b0;
      mem_rdata_reg      <= 32'd0;
      bus_err_reg        <= 1'b0;
      rom_addr_valid_reg <= 1'b0;
      rom_addr_reg       <= '0;
      ram_addr_valid_reg <= 1'b0;
      ram_addr_reg       <= '0;
      ram_wdata_reg      <= 32'd0;
      ram_wr_en_reg      <= 4'd0;
    end else begin
      state_reg          <= state_next;
      tmo_reg            <= tmo_next;
      err_count_reg      <= err_count_next;
      mem_ready_reg      <= mem_ready_next;
      mem_rdata_reg      <= mem_rdata_next;
      bus_err_reg        <= bus_err_next;
      rom_addr_valid_reg <= rom_addr_valid_next;
      rom_addr_reg       <= rom_addr_next;
      ram_addr_valid_reg <= ram_addr_valid_next;
      ram_addr_reg       <= ram_addr_next;
      ram_wdata_reg      <= ram_wdata_next;
      ram_wr_en_reg      <= ram_wr_en_next;
    end
  end

  assign mem_ready      = mem_ready_reg;
  assign mem_rdata      = mem_rdata_reg;
  assign bus_err        = bus_err_reg;
  assign err_count      = err_count_reg;
  assign rom_addr_valid = rom_addr_valid_reg;
  assign rom_addr       = rom_addr_reg;
  assign ram_addr_valid = ram_addr_valid_reg;
  assign ram_addr       = ram_addr_reg;
  assign ram_wdata      = ram_wdata_reg;
  assign ram_wr_en      = ram_wr_en_reg;

endmodule

// File: tb/tb_rv_mem_bus.sv
// Scoreboard bench for rv_mem_bus with a combinational ROM and a one-cycle-ack RAM.
module tb_rv_mem_bus;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rom_addr_valid;
  logic [7:0]  rom_addr;
  logic        rom_data_valid;
  logic [31:0] rom_data;
  logic        ram_addr_valid;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wr_en;
  logic        ram_ack;
  logic [31:0] ram_rdata = 32'd0;
  logic        bus_err;
  logic [7:0]  err_count;

  logic rom_en = 1'b1, rom_inject = 1'b0, ack_en = 1'b1, ack_inject = 1'b0;
  logic ram_ack_model = 1'b0;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  rv_mem_bus #(
    .ROM_ADDR_BITS(8), .RAM_ADDR_BITS(8),
    .ROM_BASE(32'h0000_0000), .RAM_BASE(32'h0001_0000), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rom_addr_valid(rom_addr_valid), .rom_addr(rom_addr),
    .rom_data_valid(rom_data_valid), .rom_data(rom_data),
    .ram_addr_valid(ram_addr_valid), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wr_en(ram_wr_en), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .bus_err(bus_err), .err_count(err_count)
  );

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'h1234_5678 : {24'hC0FFEE, a};
  endfunction

  assign rom_data       = rom_word(rom_addr);
  assign rom_data_valid = (rom_addr_valid & rom_en) | rom_inject;
  assign ram_ack        = ram_ack_model | ack_inject;

  // RAM device: word initialised to 5A00_00<idx> on reset, ack one cycle after request.
  logic [31:0] ram_mem [0:63];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= 32'h5A00_0000 | i;
      ram_ack_model <= 1'b0;
    end else begin
      ram_ack_model <= ram_addr_valid & ack_en;
      if (ram_addr_valid) begin
        ram_rdata <= ram_mem[ram_addr[7:2]];
        for (int b = 0; b < 4; b++)
          if (ram_wr_en[b]) ram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  int         ram_pulses = 0;
  logic [3:0] last_wr_en = 4'd0;
  logic [7:0] last_ram_addr = 8'd0;
  logic [7:0] last_rom_addr = 8'd0;
  int         leaks = 0;
  always @(posedge clk) begin
    if (ram_addr_valid) begin
      ram_pulses    <= ram_pulses + 1;
      last_wr_en    <= ram_wr_en;
      last_ram_addr <= ram_addr;
    end
    if (rom_addr_valid) last_rom_addr <= rom_addr;
  end
  always @(negedge clk)
    if (!mem_ready && (mem_rdata !== 32'd0 || bus_err !== 1'b0)) leaks <= leaks + 1;

  task automatic do_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         output logic [31:0] rd, output logic er, output int lat,
                         output logic [7:0] ec);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    rd = 32'd0; er = 1'b0; lat = -1; ec = 8'd0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat = n; rd = mem_rdata; er = bus_err; ec = err_count;
        break;
      end
    end
    // Held through the ready cycle on purpose: the bridge must not restart on it.
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = 4'd0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] rd;
    int lat;
    int early;
    sb.push_back('{32'h1234_5678, 1'b0, 2});
    mem_valid = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'd0;
    early = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_ready || rom_addr_valid) early++;
    end
    compared++;
    if ({mem_ready, mem_rdata, rom_addr_valid, ram_addr_valid, ram_wr_en, bus_err, err_count} !== 47'd0 || early != 0) begin
      mismatched++;
      $display("FAIL reset_outputs: ready=%b rdata=%h err_count=%0d early=%0d required all 0", mem_ready, mem_rdata, err_count, early);
    end
    resetn = 1'b1;
    lat = -1; rd = 32'd0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (mem_ready) begin lat = n; rd = mem_rdata; break; end
    end
    @(posedge clk); #1; mem_valid = 1'b0;
    e = sb.pop_front();
    compared++;
    if (lat != e.lat || rd !== e.rdata) begin
      mismatched++;
      $display("FAIL reset_release_first: lat=%0d rdata=%h required lat=%0d rdata=%h", lat, rd, e.lat, e.rdata);
    end
    $display("test_reset: first ROM read after release lat=%0d rdata=%h", lat, rd);
  endtask

  task automatic test_rom_read();
    logic [7:0] addrs [2] = '{8'h10, 8'h44};
    exp_t e;
    logic [31:0] rd; logic er; int lat; logic [7:0] ec;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{rom_word(addrs[i]), 1'b0, 2});
      do_xfer({24'd0, addrs[i]}, 32'd0, 4'd0, rd, er, lat, ec);
      e = sb.pop_front();
      compared++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat || last_rom_addr !== addrs[i]) begin
        mismatched++;
        $display("FAIL rom_read_%0d: rdata=%h err=%b lat=%0d rom_addr=%h required %h 0 %0d %h",
                 i, rd, er, lat, last_rom_addr, e.rdata, e.lat, addrs[i]);
      end
      $display("test_rom_read: addr=%h rdata=%h lat=%0d", addrs[i], rd, lat);
    end
  endtask

  task automatic test_ram_write_read();
    exp_t e;
    logic [31:0] rd; logic er; int lat; logic [7:0] ec;
    int p0;
    p0 = ram_pulses;
    sb.push_back('{32'd0, 1'b0, 3});
    do_xfer(32'h0001_0004, 32'hA5A5_A5A5, 4'b0011, rd, er, lat, ec);
    e = sb.pop_front();
    compared++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat || ram_pulses - p0 != 1 ||
        last_wr_en !== 4'b0011 || last_ram_addr !== 8'h04) begin
      mismatched++;
      $display("FAIL ram_write: rdata=%h lat=%0d pulses=%0d wr_en=%b addr=%h required 0 3 1 0011 04",
               rd, lat, ram_pulses - p0, last_wr_en, last_ram_addr);
    end
    $display("test_ram_write: addr=00010004 wstrb=0011 lat=%0d", lat);
    sb.push_back('{32'h5A00_A5A5, 1'b0, 3});
    sb.push_back('{32'h0BAD_F00D, 1'b0, 3});
    do_xfer(32'h0001_0004, 32'hFFFF_FFFF, 4'b0000, rd, er, lat, ec);
    e = sb.pop_front();
    compared++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat || last_wr_en !== 4'b0000) begin
      mismatched++;
      $display("FAIL ram_read: rdata=%h err=%b lat=%0d wr_en=%b required %h 0 %0d 0000", rd, er, lat, last_wr_en, e.rdata, e.lat);
    end
    $display("test_ram_read: addr=00010004 rdata=%h lat=%0d", rd, lat);
    do_xfer(32'h0001_00FC, 32'h0BAD_F00D, 4'b1111, rd, er, lat, ec);
    do_xfer(32'h0001_00FC, 32'd0, 4'b0000, rd, er, lat, ec);
    e = sb.pop_front();
    compared++;
    if (rd !== e.rdata || lat != e.lat || last_ram_addr !== 8'hFC) begin
      mismatched++;
      $display("FAIL ram_top_word: rdata=%h lat=%0d addr=%h required %h %0d FC", rd, lat, last_ram_addr, e.rdata, e.lat);
    end
    $display("test_ram_read: addr=000100FC rdata=%h lat=%0d", rd, lat);
  endtask

  task automatic test_rom_write_err();
    exp_t e;
    logic [31:0] rd; logic er; int lat; logic [7:0] ec;
    sb.push_back('{32'hDEAD_BEEF, 1'b1, 1});
    do_xfer(32'h0000_0008, 32'h1111_1111, 4'b1111, rd, er, lat, ec);
    e = sb.pop_front();
    compared++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat || ec !== 8'd1) begin
      mismatched++;
      $display("FAIL rom_write_err: rdata=%h err=%b lat=%0d err_count=%0d required %h 1 %0d 1", rd, er, lat, ec, e.rdata, e.lat);
    end
    $display("test_rom_write_err: rdata=%h bus_err=%b lat=%0d err_count=%0d", rd, er, lat, ec);
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [31:0] rd; logic er; int lat; logic [7:0] ec;
    int p0;
    ack_en = 1'b0;
    p0 = ram_pulses;
    sb.push_back('{32'hDEAD_BEEF, 1'b1, TIMEOUT + 1});
    do_xfer(32'h0001_0020, 32'd0, 4'd0, rd, er, lat, ec);
    e = sb.pop_front();
    compared++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat || ec !== 8'd2 || ram_pulses - p0 != 1) begin
      mismatched++;
      $display("FAIL ram_timeout: rdata=%h err=%b lat=%0d err_count=%0d pulses=%0d required %h 1 %0d 2 1",
               rd, er, lat, ec, ram_pulses - p0, e.rdata, e.lat);
    end
    $display("test_timeout: RAM lat=%0d err_count=%0d", lat, ec);
    ack_en = 1'b1;
    rom_en = 1'b0;
    sb.push_back('{32'hDEAD_BEEF, 1'b1, TIMEOUT + 1});
    do_xfer(32'h0000_0020, 32'd0, 4'd0, rd, er, lat, ec);
    e = sb.pop_front();
    compared++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat || ec !== 8'd3 || rom_addr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rom_timeout: rdata=%h err=%b lat=%0d err_count=%0d rom_valid=%b required %h 1 %0d 3 0",
               rd, er, lat, ec, rom_addr_valid, e.rdata, e.lat);
    end
    $display("test_timeout: ROM lat=%0d err_count=%0d", lat, ec);
    rom_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr_t [6] = '{32'h10, 32'h0001_0008, 32'h0002_0000, 32'h0001_0008, 32'h0001_0008, 32'h0};
    logic [31:0] wd_t   [6] = '{32'h0, 32'h0, 32'h0, 32'h7711_2233, 32'h0, 32'h0};
    logic [3:0]  ws_t   [6] = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
    exp_t e;
    logic [31:0] rd; logic er; int lat; logic [7:0] ec;
    int p0;
    p0 = ram_pulses;
    sb.push_back('{32'h1234_5678, 1'b0, 2});
    sb.push_back('{32'h5A00_0002, 1'b0, 3});
    sb.push_back('{32'hDEAD_BEEF, 1'b1, 1});
    sb.push_back('{32'h0000_0000, 1'b0, 3});
    sb.push_back('{32'h7700_0002, 1'b0, 3});
    sb.push_back('{32'hC0FF_EE00, 1'b0, 2});
    for (int i = 0; i < 6; i++) begin
      do_xfer(addr_t[i], wd_t[i], ws_t[i], rd, er, lat, ec);
      e = sb.pop_front();
      compared++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
        mismatched++;
        $display("FAIL b2b_%0d: rdata=%h err=%b lat=%0d required %h %b %0d", i, rd, er, lat, e.rdata, e.err, e.lat);
      end
      $display("test_back_to_back: #%0d addr=%h rdata=%h err=%b lat=%0d", i, addr_t[i], rd, er, lat);
    end
    compared++;
    if (ram_pulses - p0 != 3 || err_count !== 8'd4) begin
      mismatched++;
      $display("FAIL b2b_once: ram_pulses=%0d err_count=%0d required 3 4", ram_pulses - p0, err_count);
    end
  endtask

  task automatic test_err_saturate();
    logic [31:0] rd; logic er; int lat; logic [7:0] ec;
    int exp_cnt;
    exp_cnt = 4;
    for (int i = 0; i < 300; i++) begin
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      sb.push_back('{32'hDEAD_BEEF, 1'b1, 1});
      do_xfer(32'h4000_0000 + 32'(i * 4), 32'd0, 4'd0, rd, er, lat, ec);
      begin
        exp_t e;
        e = sb.pop_front();
        compared++;
        if (rd !== e.rdata || er !== e.err || lat != e.lat || ec !== 8'(exp_cnt)) begin
          mismatched++;
          $display("FAIL unmapped_%0d: rdata=%h err=%b lat=%0d err_count=%0d required %h 1 1 %0d", i, rd, er, lat, ec, e.rdata, exp_cnt);
        end
      end
    end
    $display("test_err_saturate: 300 unmapped accesses err_count=%0d", err_count);
  endtask

  task automatic test_reset_mid_ram();
    int spurious;
    ack_en = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0001_0010; mem_wstrb = 4'd0;
    @(posedge clk); @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    compared++;
    if ({mem_ready, mem_rdata, rom_addr_valid, rom_addr, ram_addr_valid, ram_addr, ram_wdata, ram_wr_en, bus_err, err_count} !== 95'd0) begin
      mismatched++;
      $display("FAIL async_reset: ready=%b ram_addr=%h err_count=%0d required all 0", mem_ready, ram_addr, err_count);
    end
    @(negedge clk); mem_valid = 1'b0;
    @(negedge clk); resetn = 1'b1;
    ack_en = 1'b1;
    ack_inject = 1'b1; rom_inject = 1'b1;
    @(negedge clk); ack_inject = 1'b0; rom_inject = 1'b0;
    spurious = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready || bus_err || ram_addr_valid || rom_addr_valid) spurious++;
    end
    compared++;
    if (spurious != 0 || err_count !== 8'd0) begin
      mismatched++;
      $display("FAIL late_ack_ignored: spurious=%0d err_count=%0d required 0 0", spurious, err_count);
    end
    $display("test_reset_mid_ram: outputs cleared, late ack ignored, spurious=%0d", spurious);
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_ram_write_read();
    test_rom_write_err();
    test_timeout();
    test_back_to_back();
    test_err_saturate();
    test_reset_mid_ram();
    compared++;
    if (leaks != 0) begin
      mismatched++;
      $display("FAIL idle_rdata_zero: leak_cycles=%0d required 0", leaks);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
